// File: rtl/ram_demo_pkg.sv
// Shared types and defaults for the RAM demo fill/dump sequencer.
package ram_demo_pkg;

  localparam int unsigned StateW   = 3;
  localparam int unsigned DefAddrW = 8;
  localparam int unsigned DefDataW = 8;

  typedef enum logic [StateW-1:0] {
    StIdle,
    StFill,
    StRdAddr,
    StRdCap,
    StTxWait
  } state_e;

endpackage

// File: rtl/ram_addr_ctr.sv
// RAM address counter shared by the fill and dump paths; term flags the last location.
module ram_addr_ctr
  import ram_demo_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] cnt,
  output logic              term
);

  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign term = (cnt_q == '1);

endmodule

// File: rtl/ram_dump_ctrl.sv
// Fill/dump sequencer: writes a counting pattern into the RAM and streams it out via the UART.
// Define RAM_DUMP_CHK_EN to add the err_cnt read-back checker.
module ram_dump_ctrl
  import ram_demo_pkg::*;
#(
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned FILL_SEED = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_start,
  input  logic              rd_start,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              tx_en,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_done,
  output logic              busy,
  output logic              filled,
`ifdef RAM_DUMP_CHK_EN
  output logic [ADDR_W:0]   err_cnt,
`endif
  output logic              dump_done
);

  state_e            state_q, state_d;
  logic              filled_q, filled_d;
  logic              tx_en_q, tx_en_d;
  logic              dump_done_q, dump_done_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [1:0]        lat_q, lat_d;
  logic              ctr_clr, ctr_inc, ctr_term;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] pattern;
  logic              rd_accept;

  ram_addr_ctr #(
    .ADDR_W(ADDR_W)
  ) u_addr_ctr (
    .clk (clk),
    .rst (rst),
    .clr (ctr_clr),
    .inc (ctr_inc),
    .cnt (addr),
    .term(ctr_term)
  );

  assign pattern   = DATA_W'(32'(addr) + FILL_SEED);
  assign rd_accept = (state_q == StIdle) && !wr_start && rd_start && filled_q;

  always_comb begin
    state_d     = state_q;
    filled_d    = filled_q;
    tx_data_d   = tx_data_q;
    lat_d       = lat_q;
    tx_en_d     = 1'b0;
    dump_done_d = 1'b0;
    ctr_clr     = 1'b0;
    ctr_inc     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (wr_start) begin
          state_d  = StFill;
          filled_d = 1'b0;
          ctr_clr  = 1'b1;
        end else if (rd_accept) begin
          state_d = StRdAddr;
          lat_d   = '0;
          ctr_clr = 1'b1;
        end
      end
      StFill: begin
        ctr_inc = 1'b1;
        if (ctr_term) begin
          state_d  = StIdle;
          filled_d = 1'b1;
        end
      end
      StRdAddr: begin
        // Hold the address for RD_LAT cycles so ram_rdata is valid in StRdCap.
        if (lat_q == 2'(RD_LAT - 1)) begin
          state_d = StRdCap;
          lat_d   = '0;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      StRdCap: begin
        tx_data_d = ram_rdata;
        tx_en_d   = 1'b1;
        state_d   = StTxWait;
      end
      StTxWait: begin
        if (tx_done) begin
          if (ctr_term) begin
            dump_done_d = 1'b1;
            ctr_clr     = 1'b1;
            state_d     = StIdle;
          end else begin
            ctr_inc = 1'b1;
            lat_d   = '0;
            state_d = StRdAddr;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      filled_q    <= 1'b0;
      tx_en_q     <= 1'b0;
      dump_done_q <= 1'b0;
      tx_data_q   <= '0;
      lat_q       <= '0;
    end else begin
      state_q     <= state_d;
      filled_q    <= filled_d;
      tx_en_q     <= tx_en_d;
      dump_done_q <= dump_done_d;
      tx_data_q   <= tx_data_d;
      lat_q       <= lat_d;
    end
  end

  assign ram_we    = (state_q == StFill);
  assign ram_addr  = addr;
  assign ram_wdata = ram_we ? pattern : '0;
  assign tx_en     = tx_en_q;
  assign tx_data   = tx_data_q;
  assign busy      = (state_q != StIdle);
  assign filled    = filled_q;
  assign dump_done = dump_done_q;

`ifdef RAM_DUMP_CHK_EN
  logic [ADDR_W:0] err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (rd_accept) begin
      err_d = '0;
    end else if ((state_q == StRdCap) && (ram_rdata != pattern) && (err_q != '1)) begin
      err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_cnt = err_q;
`endif

endmodule
